// File: rtl/alu_divider32_seq_pkg.sv
// Shared ALU definitions for the sequential divider.
//   state_t          : divider control FSM states
//   ALU_WIDTH        : ALU datapath width
//   DIV_ZERO_QUOTIENT: quotient reported for a division by zero (all ones)
package alu_divider32_seq_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/alu_divider32_seq_subtractor32.sv
// 32-bit unsigned subtractor used for the divider's trial subtraction.
// Ports:
//   A, B  : operands
//   Diff  : A - B (modulo 2**32)
//   Bout  : borrow out, 1 when A < B (unsigned)
module subtractor32 (
  output logic        Bout,
  output logic [31:0] Diff,
  input  logic [31:0] A,
  input  logic [31:0] B
);

  assign {Bout, Diff} = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/alu_divider32_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : request, sampled only while idle
//   dividend, divisor  : operands, captured when a start is accepted
//   busy               : high while iterating
//   done               : one-cycle pulse when results become valid
//   quotient/remainder : results, held until the next completion
//   div_zero           : divisor was zero for the finished operation
module alu_divider32_seq
  import alu_divider32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t           state, state_next;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [CNT_W-1:0] count;

  logic             msb;
  logic [WIDTH-1:0] rs, diff, r_next, q_next;
  logic             bout;
  logic             last_iter;

  // Shift the next dividend bit into the partial remainder. The bit shifted
  // out (msb) is the 33rd bit of the partial remainder: when set, Rs >= D is
  // guaranteed and the low 32 bits of the subtraction are still exact.
  assign msb = r_reg[WIDTH-1];
  assign rs  = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  subtractor32 u_sub (
    .Bout (bout),
    .Diff (diff),
    .A    (rs),
    .B    (d_reg)
  );

  always_comb begin
    r_next = rs;
    q_next = {q_reg[WIDTH-2:0], 1'b0};
    if (msb | ~bout) begin
      r_next    = diff;
      q_next[0] = 1'b1;
    end
  end

  assign last_iter = (count == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            r_reg    <= '0;
            q_reg    <= dividend;
            d_reg    <= divisor;
            count    <= '0;
            div_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= DIV_ZERO_QUOTIENT;
              remainder <= dividend;
            end
          end
        end
        S_RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider32_seq.sv
module tb_alu_divider32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  always #5 clk = ~clk;

  alu_divider32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, all ones / dividend on zero divisor.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
      end
    end
  end

  // Issue one operation. mid_n: cycle (after accept) at which a stray start
  // is pulsed; abort_n: cycle at which reset is asserted; 0 disables either.
  // hold_start: drive a stray start during the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int mid_n, input int abort_n, input bit hold_start);
    int n;
    int busy_cnt;
    bit got_done;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (abort_n == 0) sb.push_back(model(a, b));
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n        = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    while (n < 40 && !got_done) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        chk("done_latency", n, (b == 0) ? 32'd1 : 32'd33);
        chk("busy_cycles", busy_cnt, (b == 0) ? 32'd0 : 32'd32);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (hold_start) begin
          start    = 1'b1;
          dividend = 32'd9;
          divisor  = 32'd3;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end else begin
        if (start) start = 1'b0;
        if (n == mid_n) begin
          start    = 1'b1;
          dividend = 32'd9;
          divisor  = 32'd3;
        end
        if (n == abort_n) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy", {31'd0, busy}, 32'd0);
          chk("abort_done", {31'd0, done}, 32'd0);
          chk("abort_quotient", quotient, 32'd0);
          chk("abort_remainder", remainder, 32'd0);
          chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
          repeat (40) @(negedge clk);
          return;
        end
      end
    end
    if (!got_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in 40 cycles expected done");
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  initial begin
    logic [31:0] a, b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;

    run_op(32'd100, 32'd7, 0, 0, 1'b0);
    run_op(32'd2, 32'hA, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1'b0);
    run_op(32'd5, 32'd0, 0, 0, 1'b0);
    run_op(32'd100, 32'd7, 10, 0, 1'b0);
    run_op(32'd123, 32'd4, 0, 15, 1'b0);
    run_op(32'h0AAB_B002, 32'h0BB0_0002, 0, 0, 1'b0);
    run_op(32'd77, 32'd0, 0, 0, 1'b1);
    run_op(32'd1000, 32'd33, 0, 0, 1'b1);

    for (int unsigned i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(a, b, 0, 0, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
